crc32_mpeg: RTL and testbench

CRC32_MPEG -- requirements
Module: crc32_mpeg

---
 rtl/crc32_mpeg.sv | 49 ++++
 tb/tb_crc32_mpeg.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/crc32_mpeg.sv
// CRC-32/MPEG-2 generator: poly 0x04C11DB7, init 0xFFFFFFFF, MSB-first,
// no reflection, no final XOR; absorbs one byte per clock.
module crc32_mpeg (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ENA,
  input  logic        INIT,
  input  logic [7:0]  D,
  output logic [31:0] CRC
);

  localparam logic [31:0] POLY     = 32'h04C1_1DB7;
  localparam logic [31:0] INIT_VAL = 32'hFFFF_FFFF;

  logic [31:0] crc_q;
  logic [31:0] crc_d;

  // Eight unrolled bit-serial steps, bit 7 first, collapse into one XOR network.
  function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] d_in);
    logic [31:0] c;
    logic        fb;
    c = c_in;
    for (int unsigned i = 0; i < 8; i++) begin
      fb = c[31] ^ d_in[7 - i];
      c  = {c[30:0], 1'b0} ^ (fb ? POLY : '0);
    end
    return c;
  endfunction

  always_comb begin
    crc_d = crc_q;
    if (INIT) begin
      crc_d = INIT_VAL;
    end else if (ENA) begin
      crc_d = crc_byte(crc_q, D);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      crc_q <= INIT_VAL;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign CRC = crc_q;

endmodule

// File: tb/tb_crc32_mpeg.sv
// Self-checking bench for crc32_mpeg: directed vector table, hand-written
// reset/PAT sequences, and a randomized message-level reference model.
module tb_crc32_mpeg;

  logic        CLK;
  logic        RST;
  logic        ENA;
  logic        INIT;
  logic [7:0]  D;
  logic [31:0] CRC;

  crc32_mpeg dut (
    .CLK  (CLK),
    .RST  (RST),
    .ENA  (ENA),
    .INIT (INIT),
    .D    (D),
    .CRC  (CRC)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Reference state: the bytes of the current message since the last restart.
  logic [7:0] msg[$];

  typedef struct {
    bit          ini;
    bit          ena;
    logic [7:0]  d;
    bit          has_exp;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  // CRC of the whole message, recomputed from scratch from the algorithm definition.
  function automatic logic [31:0] model_crc();
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFF_FFFF;
    foreach (msg[k]) begin
      for (int b = 7; b >= 0; b--) begin
        fb = c[31] ^ msg[k][b];
        c  = {c[30:0], 1'b0} ^ (fb ? 32'h04C1_1DB7 : 32'h0);
      end
    end
    return c;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: CRC=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, update model at the edge, sample 1 time unit later.
  task automatic step(input bit ini, input bit en, input logic [7:0] dd, input string name);
    INIT = ini;
    ENA  = en;
    D    = dd;
    @(posedge CLK);
    if (RST)       msg.delete();
    else if (ini)  msg.delete();
    else if (en)   msg.push_back(dd);
    #1;
    check(name, CRC, model_crc());
  endtask

  task automatic add_vec(input bit ini, input bit en, input logic [7:0] dd,
                         input bit he, input logic [31:0] ex);
    vec_t v;
    v.ini = ini; v.ena = en; v.d = dd; v.has_exp = he; v.exp = ex;
    vecs.push_back(v);
  endtask

  logic [7:0] ascii[9];
  logic [7:0] pat[12];
  logic [7:0] resid[4];

  initial begin
    ascii = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    pat   = '{8'h00, 8'hB0, 8'h0D, 8'h00, 8'h01, 8'hC1, 8'h00, 8'h00, 8'h00, 8'h01, 8'hF0, 8'h00};
    resid = '{8'h03, 8'h76, 8'hE6, 8'hE7};

    // Directed table: check value, hold, residue, INIT-over-ENA, re-run.
    add_vec(1, 0, 8'h00, 1, 32'hFFFF_FFFF);
    for (int i = 0; i < 9; i++) add_vec(0, 1, ascii[i], i == 8, 32'h0376_E6E7);
    add_vec(0, 0, 8'h55, 1, 32'h0376_E6E7);
    add_vec(0, 0, 8'hA5, 1, 32'h0376_E6E7);
    for (int i = 0; i < 4; i++) add_vec(0, 1, resid[i], i == 3, 32'h0000_0000);
    add_vec(0, 1, 8'h31, 0, 32'h0);
    add_vec(0, 1, 8'h32, 0, 32'h0);
    add_vec(1, 1, 8'hAA, 1, 32'hFFFF_FFFF);
    for (int i = 0; i < 9; i++) add_vec(0, 1, ascii[i], i == 8, 32'h0376_E6E7);

    RST = 1'b1; ENA = 1'b0; INIT = 1'b0; D = 8'h00;
    #2;
    check("reset_async", CRC, 32'hFFFF_FFFF);
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 10; i++) step(0, 0, 8'($urandom), "reset_idle_hold");

    foreach (vecs[i]) begin
      step(vecs[i].ini, vecs[i].ena, vecs[i].d, "table_model");
      if (vecs[i].has_exp) check("table_const", CRC, vecs[i].exp);
    end

    // PAT section with random idle gaps between bytes.
    step(1, 0, 8'h00, "pat_init");
    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(0, 3)) step(0, 0, 8'($urandom), "pat_gap");
      step(0, 1, pat[i], "pat_byte");
    end
    check("pat_crc", CRC, 32'h2AB1_04B2);

    // Reset asserted mid-message, between edges, with ENA held high.
    step(1, 0, 8'h00, "rst_init");
    step(0, 1, 8'h12, "rst_b0");
    step(0, 1, 8'h34, "rst_b1");
    #2;
    RST = 1'b1;
    msg.delete();
    #1;
    check("rst_mid_async", CRC, 32'hFFFF_FFFF);
    step(0, 1, 8'h77, "rst_held_ena");
    check("rst_held_const", CRC, 32'hFFFF_FFFF);
    RST = 1'b0;
    for (int i = 0; i < 9; i++) step(0, 1, ascii[i], "rst_rerun");
    check("rst_rerun_const", CRC, 32'h0376_E6E7);

    // Randomized messages with gaps; INIT between messages, sometimes with ENA.
    for (int m = 0; m < 1000; m++) begin
      step(1, 1'($urandom_range(0, 1)), 8'($urandom), "rnd_init");
      for (int n = 0; n < int'($urandom_range(0, 12)); n++) begin
        repeat ($urandom_range(0, 2)) step(0, 0, 8'($urandom), "rnd_gap");
        step(0, 1, 8'($urandom), "rnd_byte");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
